// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control unit. It runs one instruction per FETCH/DECODE/EXEC/MEM/WB pass,
// drives the datapath strobes and the memory handshake, and counts retired instructions.
module multicycle_control #(
  parameter int OPCODE_W     = 7,
  parameter int ALUOP_W      = 2,
  parameter int MEM_WAIT_MAX = 15,
  parameter int RET_CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 reg_write,
  output logic [1:0]           mem_to_reg,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [RET_CNT_W-1:0] instr_retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JAL, CLS_JALR
  } cls_t;

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR  = OPCODE_W'(7'b1100111);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_RF  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_IF  = ALUOP_W'(2'b11);

  state_t                 state_reg, state_next;
  cls_t                   class_reg, dec_cls;
  logic                   dec_legal;
  logic                   timeout;
  logic [WAIT_W-1:0]      wait_reg;
  logic [RET_CNT_W-1:0]   ret_reg;
  logic                   fault_reg;

  always_comb begin
    dec_cls   = CLS_R;
    dec_legal = 1'b1;
    case (opcode)
      OP_R:     dec_cls = CLS_R;
      OP_I:     dec_cls = CLS_I;
      OP_LOAD:  dec_cls = CLS_LOAD;
      OP_STORE: dec_cls = CLS_STORE;
      OP_BR:    dec_cls = CLS_BR;
      OP_JAL:   dec_cls = CLS_JAL;
      OP_JALR:  dec_cls = CLS_JALR;
      default:  dec_legal = 1'b0;
    endcase
  end

  // A ready that arrives on the limit cycle wins over the timeout.
  assign timeout = (MEM_WAIT_MAX != 0) && (wait_reg == WAIT_LIM) && !mem_ready;

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    if (rst_n) begin
      case (state_reg)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = DECODE;
          end else if (timeout) begin
            state_next = FAULT;
          end
        end
        DECODE: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b10;
          state_next = dec_legal ? EXEC : FAULT;
        end
        EXEC: begin
          case (class_reg)
            CLS_R: begin
              alu_src_a  = 2'b01;
              alu_op     = ALU_RF;
              state_next = WB;
            end
            CLS_I: begin
              alu_src_a  = 2'b01;
              alu_src_b  = 2'b10;
              alu_op     = ALU_IF;
              state_next = WB;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src_a  = 2'b01;
              alu_src_b  = 2'b10;
              state_next = MEM;
            end
            CLS_BR: begin
              alu_src_a  = 2'b01;
              alu_op     = ALU_SUB;
              pc_write   = alu_zero;
              pc_src     = alu_zero ? 2'b01 : 2'b00;
              state_next = FETCH;
            end
            CLS_JAL: begin
              pc_write   = 1'b1;
              pc_src     = 2'b01;
              state_next = WB;
            end
            CLS_JALR: begin
              alu_src_a  = 2'b01;
              alu_src_b  = 2'b10;
              pc_write   = 1'b1;
              state_next = WB;
            end
            default: state_next = FAULT;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_we  = (class_reg == CLS_STORE);
          if (mem_ready)
            state_next = (class_reg == CLS_STORE) ? FETCH : WB;
          else if (timeout)
            state_next = FAULT;
        end
        WB: begin
          reg_write  = 1'b1;
          if (class_reg == CLS_LOAD)
            mem_to_reg = 2'b01;
          else if (class_reg == CLS_JAL || class_reg == CLS_JALR)
            mem_to_reg = 2'b10;
          state_next = FETCH;
        end
        FAULT:   state_next = FAULT;
        default: state_next = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      class_reg <= CLS_R;
      wait_reg  <= '0;
      ret_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE)
        class_reg <= dec_cls;
      if (state_reg != FAULT) begin
        if ((state_next == FETCH || state_next == MEM) && state_next != state_reg)
          wait_reg <= '0;
        else if (mem_req && !mem_ready)
          wait_reg <= wait_reg + 1'b1;
      end
      if (state_next == FETCH &&
          (state_reg == EXEC || state_reg == MEM || state_reg == WB))
        ret_reg <= ret_reg + 1'b1;
      if (state_next == FAULT)
        fault_reg <= 1'b1;
    end
  end

  assign state         = state_reg;
  assign fault         = fault_reg;
  assign instr_retired = ret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds a per-instruction expected cycle trace from the
// instruction class and memory wait counts, then replays and checks it cycle by cycle.
module tb_multicycle_control;

  localparam int WMAX = 4;
  localparam int RW   = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic          alu_zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, fault;
  logic [1:0]    pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic [2:0]    state;
  logic [RW-1:0] instr_retired;

  multicycle_control #(
    .OPCODE_W(7), .ALUOP_W(2), .MEM_WAIT_MAX(WMAX), .RET_CNT_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fault(fault),
    .state(state), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          req, we, iod, irw, pcw;
    logic [1:0]    pcs, sa, sb, aop;
    logic          rw;
    logic [1:0]    m2r;
    logic          flt;
    logic [RW-1:0] ret;
    logic          rdy, zero;
    logic [6:0]    opc;
  } cyc_t;

  cyc_t          q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [RW-1:0] exp_ret = '0;
  logic [6:0]    legal_ops [7] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c = '0;
    c.st   = st;
    c.ret  = exp_ret;
    c.rdy  = 1'($urandom);
    c.zero = 1'($urandom);
    c.opc  = 7'($urandom);
    return c;
  endfunction

  function automatic void push_fault(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(3'd5);
      c.flt = 1'b1;
      q.push_back(c);
    end
  endfunction

  // Pushes the ready-low cycles of a memory wait; returns 1 when the wait outlasts the limit.
  function automatic bit push_wait(input cyc_t base, input int waits);
    cyc_t c;
    int n = (waits > WMAX) ? WMAX + 1 : waits;
    for (int i = 0; i < n; i++) begin
      c = base;
      c.rdy  = 1'b0;
      c.zero = 1'($urandom);
      c.opc  = 7'($urandom);
      q.push_back(c);
    end
    return waits > WMAX;
  endfunction

  function automatic void build_instr(input logic [6:0] op, input int fw, input int mw,
                                      input logic z);
    cyc_t c;
    bit is_ld = (op == OP_LOAD);
    bit is_st = (op == OP_STORE);
    bit is_j  = (op == OP_JAL) || (op == OP_JALR);
    bit legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    c = blank(3'd0); c.req = 1'b1; c.sb = 2'b01;
    if (push_wait(c, fw)) begin push_fault(6); return; end
    c = blank(3'd0); c.req = 1'b1; c.sb = 2'b01; c.rdy = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
    q.push_back(c);
    c = blank(3'd1); c.sa = 2'b10; c.sb = 2'b10; c.opc = op;
    q.push_back(c);
    if (!legal) begin push_fault(10); return; end
    c = blank(3'd2);
    case (op)
      OP_R:              begin c.sa = 2'b01; c.sb = 2'b00; c.aop = 2'b10; end
      OP_I:              begin c.sa = 2'b01; c.sb = 2'b10; c.aop = 2'b11; end
      OP_LOAD, OP_STORE: begin c.sa = 2'b01; c.sb = 2'b10; c.aop = 2'b00; end
      OP_BR: begin
        c.sa = 2'b01; c.aop = 2'b01; c.zero = z;
        c.pcw = z; c.pcs = z ? 2'b01 : 2'b00;
      end
      OP_JAL:  begin c.pcw = 1'b1; c.pcs = 2'b01; end
      default: begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; c.pcs = 2'b00; end
    endcase
    q.push_back(c);
    if (op == OP_BR) begin exp_ret += 1'b1; return; end
    if (is_ld || is_st) begin
      c = blank(3'd3); c.req = 1'b1; c.iod = 1'b1; c.we = is_st;
      if (push_wait(c, mw)) begin push_fault(6); return; end
      c = blank(3'd3); c.req = 1'b1; c.iod = 1'b1; c.we = is_st; c.rdy = 1'b1;
      q.push_back(c);
      if (is_st) begin exp_ret += 1'b1; return; end
    end
    c = blank(3'd4); c.rw = 1'b1;
    c.m2r = is_ld ? 2'b01 : (is_j ? 2'b10 : 2'b00);
    q.push_back(c);
    exp_ret += 1'b1;
  endfunction

  // Replays queued cycles (all of them when limit is 0); starts and ends just after a rising edge.
  task automatic run_trace(input string tag, input int limit);
    cyc_t e, g;
    int n = 0;
    while (q.size() > 0 && (limit == 0 || n < limit)) begin
      e = q.pop_front();
      opcode = e.opc; mem_ready = e.rdy; alu_zero = e.zero;
      @(negedge clk);
      g = e;
      g.st = state; g.req = mem_req; g.we = mem_we; g.iod = i_or_d; g.irw = ir_write;
      g.pcw = pc_write; g.pcs = pc_src; g.sa = alu_src_a; g.sb = alu_src_b; g.aop = alu_op;
      g.rw = reg_write; g.m2r = mem_to_reg; g.flt = fault; g.ret = instr_retired;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got=%h required=%h (state %0d vs %0d)",
                 tag, n, g, e, g.st, e.st);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = '0;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b1; opcode = OP_R;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
         alu_op, reg_write, mem_to_reg} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_strobes: got req=%b ir=%b pcw=%b b=%b required all 0",
               mem_req, ir_write, pc_write, alu_src_b);
    end
    vectors++;
    if (state !== 3'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d required 0", state);
    end
    vectors++;
    if (fault !== 1'b0 || instr_retired !== '0) begin
      miscompares++;
      $display("FAIL reset_flags: got fault=%b ret=%0d required 0/0", fault, instr_retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ret = '0; mem_ready = 1'b0;
  endtask

  task automatic test_r_type();
    build_instr(OP_R, 1, 0, 1'b0);
    run_trace("r_type", 0);
    vectors++;
    if (instr_retired !== 4'd1) begin
      miscompares++; $display("FAIL r_type_retire: got %0d required 1", instr_retired);
    end
  endtask

  task automatic test_load_store();
    build_instr(OP_LOAD, 3, 2, 1'b0);
    build_instr(OP_STORE, $urandom_range(0, WMAX), $urandom_range(0, WMAX), 1'b0);
    run_trace("load_store", 0);
  endtask

  task automatic test_branch();
    build_instr(OP_BR, $urandom_range(0, 2), 0, 1'b1);
    build_instr(OP_BR, $urandom_range(0, 2), 0, 1'b0);
    run_trace("branch", 0);
  endtask

  task automatic test_jumps();
    build_instr(OP_JAL, $urandom_range(0, 2), 0, 1'b0);
    build_instr(OP_JALR, $urandom_range(0, 2), 0, 1'b0);
    run_trace("jumps", 0);
  endtask

  task automatic test_illegal();
    build_instr(OP_LUI, 1, 0, 1'b0);
    run_trace("illegal", 0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 3'd0 || fault !== 1'b0 || instr_retired !== '0) begin
      miscompares++;
      $display("FAIL illegal_clear: got state=%0d fault=%b ret=%0d required 0/0/0",
               state, fault, instr_retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ret = '0;
    build_instr(OP_I, 0, 0, 1'b0);
    run_trace("after_fault", 0);
  endtask

  task automatic test_timeout();
    build_instr(OP_R, WMAX + 1, 0, 1'b0);
    run_trace("fetch_timeout", 0);
    pulse_reset();
    build_instr(OP_R, WMAX, 0, 1'b0);
    build_instr(OP_STORE, 0, WMAX, 1'b0);
    run_trace("ready_at_limit", 0);
    build_instr(OP_LOAD, 0, WMAX + 1, 1'b0);
    run_trace("mem_timeout", 0);
    pulse_reset();
  endtask

  task automatic test_midop_reset();
    build_instr(OP_STORE, 0, 3, 1'b0);
    run_trace("midop", 4);
    mem_ready = 1'b0;
    #2;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pending: got req=%b we=%b required 1/1", mem_req, mem_we);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 3'd0 || instr_retired !== '0) begin
      miscompares++;
      $display("FAIL midop_abort: got req=%b we=%b state=%0d ret=%0d required 0/0/0/0",
               mem_req, mem_we, state, instr_retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ret = '0; q.delete();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++)
      build_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, WMAX),
                  $urandom_range(0, WMAX), 1'($urandom));
    run_trace("wrap_fill", 0);
    vectors++;
    if (instr_retired !== 4'hF) begin
      miscompares++; $display("FAIL wrap_full: got %0d required 15", instr_retired);
    end
    build_instr(OP_I, 0, 0, 1'b0);
    run_trace("wrap_last", 0);
    vectors++;
    if (instr_retired !== 4'h0) begin
      miscompares++; $display("FAIL wrap_zero: got %0d required 0", instr_retired);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++)
      build_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, WMAX),
                  $urandom_range(0, WMAX), 1'($urandom));
    run_trace("back_to_back", 0);
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    test_midop_reset();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle RISC-V control unit: a registered FSM that sequences one instruction per FETCH→DECODE→EXEC→MEM→WB pass. Drives datapath strobes, a request/ready handshake to unified memory, and a retired-instruction counter. Replaces the single-cycle combinational decoder in the multi-cycle core. Adds JAL/JALR linking, memory-wait timeout and a sticky illegal-opcode fault.

Parameters:
OPCODE_W, 7, opcode field width
ALUOP_W, 2, alu_op width (≥2)
MEM_WAIT_MAX, 15, max cycles mem_req may wait for mem_ready before FAULT; 0 disables timeout
RET_CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  instruction opcode from IR; sampled only in DECODE
alu_zero  in  1  ALU zero flag, used in EXEC for branches
mem_ready  in  1  memory completion; ignored unless mem_req=1
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
i_or_d  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR and link register (PC+4)
pc_write  out  1  PC update strobe
pc_src  out  2  00=ALU result, 01=ALUOut (target)
alu_src_a  out  2  00=PC, 01=rs1, 10=old PC
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm
alu_op  out  ALUOP_W  00=add, 01=sub/compare, 10=R-funct, 11=I-funct
reg_write  out  1  register-file write strobe
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=link
fault  out  1  sticky fault flag
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5
instr_retired  out  RET_CNT_W  retired-instruction count, wraps to 0

Behaviour:
- Reset (async): state=FETCH, class reg=0, wait counter=0, instr_retired=0, fault=0. All strobes/selects are 0 while rst_n=0. Mid-operation reset aborts immediately; the memory side must drop an outstanding request.
- Strobes are combinational from state, latched class, mem_ready and alu_zero. State updates on the rising clk.
- FETCH: mem_req=1, i_or_d=0, a=00, b=01, alu_op=00. On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay.
- DECODE: a=10, b=10, alu_op=00 (branch/JAL target into ALUOut). Latch class from opcode.
  - Legal opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BR 1100011, JAL 1101111, JALR 1100111.
  - Any other opcode: go to FAULT. Otherwise go to EXEC.
- EXEC, by class:
  - R: a=01, b=00, alu_op=10, go to WB.
  - I: a=01, b=10, alu_op=11, go to WB.
  - LOAD/STORE: a=01, b=10, alu_op=00, go to MEM.
  - BR: a=01, b=00, alu_op=01. If alu_zero: pc_write=1, pc_src=01. Go to FETCH and retire.
  - JAL: pc_write=1, pc_src=01, go to WB.
  - JALR: a=01, b=10, alu_op=00, pc_write=1, pc_src=00, go to WB.
- MEM: mem_req=1, i_or_d=1, mem_we=1 only for STORE. On mem_ready: LOAD goes to WB; STORE goes to FETCH and retires.
- WB: reg_write=1. mem_to_reg = 01 for LOAD, 10 for JAL/JALR, 00 otherwise. Go to FETCH and retire.
- Retire: instr_retired +1 on every transition into FETCH from EXEC/MEM/WB. Wraps modulo 2^RET_CNT_W.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
  - If counter==MEM_WAIT_MAX with mem_ready=0 and MEM_WAIT_MAX≠0, go to FAULT next edge.
  - mem_ready arriving on the same cycle as the limit is accepted (no fault).
- FAULT: fault=1, all strobes 0, counter frozen. Exit only by reset.
- mem_req, mem_we and i_or_d stay stable while waiting. No store or JALR ever asserts mem_we outside MEM.

Test Plan:
- R-type (0110011), mem_ready after 1 cycle → states 0,1,2,4,0. alu_op=10 in EXEC, reg_write=1 only in WB, instr_retired 0→1.
- LOAD with mem_ready delayed 3 cycles in FETCH and 2 in MEM → mem_req held high throughout, mem_to_reg=01 in WB, retire=1. STORE → mem_we=1 only in MEM, reg_write never 1.
- BR with alu_zero=1 → pc_write=1, pc_src=01 in EXEC. alu_zero=0 → pc_write=0. Both return to FETCH and retire.
- JAL/JALR → pc_write in EXEC (pc_src 01/00), WB mem_to_reg=10, mem_we never asserted.
- Opcode 0110111 → FAULT after DECODE, fault=1 sticky through 10 cycles; rst_n pulse clears to FETCH with count=0.
- MEM_WAIT_MAX=4, mem_ready held low → FAULT after 4 wait cycles; ready on the 4th cycle → no fault. Counter at 2^RET_CNT_W−1 plus one retire → 0.
